// File: rtl/cursor_grid_ctrl.sv
// Grid cursor controller: debounced 4-key navigation plus a registered VGA outline overlay.
// Optional key auto-repeat is enabled by defining CURSOR_AUTOREPEAT_EN.
module cursor_grid_ctrl #(
    parameter int          GRID_COLS       = 10,
    parameter int          GRID_ROWS       = 10,
    parameter int          CELL_W          = 32,
    parameter int          CELL_H          = 32,
    parameter int          X_ORIGIN        = 160,
    parameter int          Y_ORIGIN        = 80,
    parameter int          BORDER          = 3,
    parameter logic [23:0] CUR_COLOR       = 24'hFF0000,
    parameter int          WRAP            = 1,
    parameter int          DEBOUNCE_CYCLES = 500000
`ifdef CURSOR_AUTOREPEAT_EN
    ,
    parameter int          REPEAT_FIRST    = 25000000,
    parameter int          REPEAT_NEXT     = 6250000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_n,
    input  logic        move_en,
    input  logic [9:0]  xPixel,
    input  logic [9:0]  yPixel,
    input  logic        active_pixels,
    output logic [4:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        moved,
    output logic [23:0] vga_color
);

    localparam int         DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [4:0] COL_MAX = 5'(GRID_COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(GRID_ROWS - 1);
    localparam logic [10:0] XO = 11'(X_ORIGIN);
    localparam logic [10:0] YO = 11'(Y_ORIGIN);
    localparam logic [10:0] CW = 11'(CELL_W);
    localparam logic [10:0] CH = 11'(CELL_H);
    localparam logic [10:0] BW = 11'(BORDER);

    typedef enum logic [1:0] {IDLE, HELD, RELEASED} key_state_t;

    logic [3:0]     sync1, sync2, acc;
    logic [DBW-1:0] db_cnt [4];
    key_state_t     state_q [4];
    key_state_t     state_d [4];
    logic [3:0]     press, evt_q, rpt_fire, mv;
    logic [4:0]     col_d, row_d;

    // Synchronizers reset to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Counter runs only while the synchronized level differs from the accepted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '1;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) state_q[i] <= IDLE;
        end else begin
            for (int unsigned i = 0; i < 4; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:     if (!acc[i]) state_d[i] = HELD;
                HELD:     if (acc[i])  state_d[i] = RELEASED;
                RELEASED: state_d[i] = IDLE;
                default:  state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 4; i++)
            press[i] = ((state_q[i] == IDLE) && (state_d[i] == HELD)) || rpt_fire[i];
    end

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int RW = $clog2(((REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT) + 1);

    logic [RW-1:0] rpt_cnt [4];
    logic [3:0]    rpt_first;

    always_comb begin
        rpt_fire = '0;
        for (int unsigned i = 0; i < 4; i++)
            rpt_fire[i] = (state_q[i] == HELD) && !acc[i] &&
                          (rpt_cnt[i] == (rpt_first[i] ? RW'(REPEAT_FIRST - 1) : RW'(REPEAT_NEXT - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_first <= '1;
            for (int unsigned i = 0; i < 4; i++) rpt_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if ((state_q[i] != HELD) || acc[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b1;
                end else if (rpt_fire[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) evt_q <= '0;
        else     evt_q <= press;
    end

    assign mv = evt_q & {4{move_en}};

    // Opposing events cancel; one horizontal plus one vertical gives a diagonal.
    always_comb begin
        col_d = cur_col;
        row_d = cur_row;
        if (mv[0] && !mv[1])
            col_d = (cur_col == COL_MAX) ? ((WRAP != 0) ? 5'd0 : cur_col) : cur_col + 5'd1;
        else if (mv[1] && !mv[0])
            col_d = (cur_col == 5'd0) ? ((WRAP != 0) ? COL_MAX : cur_col) : cur_col - 5'd1;
        if (mv[2] && !mv[3])
            row_d = (cur_row == ROW_MAX) ? ((WRAP != 0) ? 5'd0 : cur_row) : cur_row + 5'd1;
        else if (mv[3] && !mv[2])
            row_d = (cur_row == 5'd0) ? ((WRAP != 0) ? ROW_MAX : cur_row) : cur_row - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_col <= '0;
            cur_row <= '0;
            moved   <= 1'b0;
        end else begin
            cur_col <= col_d;
            cur_row <= row_d;
            moved   <= (col_d != cur_col) || (row_d != cur_row);
        end
    end

    logic [10:0] px, py, x0, y0;
    logic        in_x, in_y, edge_x, edge_y;

    always_comb begin
        px     = {1'b0, xPixel};
        py     = {1'b0, yPixel};
        x0     = XO + 11'(cur_col) * CW;
        y0     = YO + 11'(cur_row) * CH;
        in_x   = (px >= x0) && (px < x0 + CW);
        in_y   = (py >= y0) && (py < y0 + CH);
        edge_x = (px < x0 + BW) || (px >= x0 + CW - BW);
        edge_y = (py < y0 + BW) || (py >= y0 + CH - BW);
    end

    always_ff @(posedge clk) begin
        if (rst)
            vga_color <= '0;
        else if (active_pixels && in_x && in_y && (edge_x || edge_y))
            vga_color <= CUR_COLOR;
        else
            vga_color <= '0;
    end

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Directed bench for cursor_grid_ctrl: a wrapping and a clamping instance share all inputs.
// The auto-repeat scenario is built only when CURSOR_AUTOREPEAT_EN is defined.
module tb_cursor_grid_ctrl;

    logic        clk = 1'b0;
    logic        rst, move_en, active_pixels;
    logic [3:0]  key_n;
    logic [9:0]  xp, yp;
    logic [4:0]  col_a, row_a, col_c, row_c;
    logic        moved_a, moved_c;
    logic [23:0] vga_a, vga_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mv_a  = 0;
    int mv_c  = 0;
    int pulse_t[$];

    always #5 clk = ~clk;

`ifdef CURSOR_AUTOREPEAT_EN
    cursor_grid_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_FIRST(20), .REPEAT_NEXT(8)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .move_en(move_en),
        .xPixel(xp), .yPixel(yp), .active_pixels(active_pixels),
        .cur_col(col_a), .cur_row(row_a), .moved(moved_a), .vga_color(vga_a));
`else
    cursor_grid_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .move_en(move_en),
        .xPixel(xp), .yPixel(yp), .active_pixels(active_pixels),
        .cur_col(col_a), .cur_row(row_a), .moved(moved_a), .vga_color(vga_a));
`endif

    cursor_grid_ctrl #(.DEBOUNCE_CYCLES(4), .WRAP(0)) dut_c (
        .clk(clk), .rst(rst), .key_n(key_n), .move_en(move_en),
        .xPixel(xp), .yPixel(yp), .active_pixels(active_pixels),
        .cur_col(col_c), .cur_row(row_c), .moved(moved_c), .vga_color(vga_c));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (moved_a) begin
                mv_a++;
                pulse_t.push_back(cyc);
            end
            if (moved_c) mv_c++;
        end
    endtask

    task automatic clr();
        mv_a = 0;
        mv_c = 0;
        pulse_t.delete();
    endtask

    task automatic press(input logic [3:0] mask, input int low);
        key_n = ~mask;
        step(low);
        key_n = 4'hF;
        step(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        total++; if (col_a !== 5'd0) begin bad++; $display("FAIL reset_col got=%0d want=0", col_a); end
        total++; if (row_a !== 5'd0) begin bad++; $display("FAIL reset_row got=%0d want=0", row_a); end
        total++; if (moved_a !== 1'b0) begin bad++; $display("FAIL reset_moved got=%b want=0", moved_a); end
        total++; if (vga_a !== 24'h000000) begin bad++; $display("FAIL reset_vga got=%h want=000000", vga_a); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single_press();
        clr();
        press(4'b0001, 10);
        total++; if (col_a !== 5'd1) begin bad++; $display("FAIL press_col got=%0d want=1", col_a); end
        total++; if (row_a !== 5'd0) begin bad++; $display("FAIL press_row got=%0d want=0", row_a); end
        total++; if (mv_a != 1) begin bad++; $display("FAIL press_moved_cycles got=%0d want=1", mv_a); end
    endtask

    task automatic test_bounce();
        clr();
        for (int i = 0; i < 3; i++) begin
            key_n = 4'hE; step(2);
            key_n = 4'hF; step(2);
        end
        step(10);
        total++; if (mv_a != 0) begin bad++; $display("FAIL bounce_moved got=%0d want=0", mv_a); end
        total++; if (col_a !== 5'd1) begin bad++; $display("FAIL bounce_col got=%0d want=1", col_a); end
    endtask

    task automatic test_edges();
        for (int i = 0; i < 8; i++) press(4'b0001, 10);
        total++; if (col_a !== 5'd9) begin bad++; $display("FAIL walk_col_wrap got=%0d want=9", col_a); end
        total++; if (col_c !== 5'd9) begin bad++; $display("FAIL walk_col_clamp got=%0d want=9", col_c); end
        clr();
        press(4'b0001, 10);
        total++; if (col_a !== 5'd0) begin bad++; $display("FAIL wrap_col got=%0d want=0", col_a); end
        total++; if (mv_a != 1) begin bad++; $display("FAIL wrap_moved got=%0d want=1", mv_a); end
        total++; if (col_c !== 5'd9) begin bad++; $display("FAIL clamp_col got=%0d want=9", col_c); end
        total++; if (mv_c != 0) begin bad++; $display("FAIL clamp_moved got=%0d want=0", mv_c); end
    endtask

    task automatic test_cancel_diag();
        clr();
        press(4'b0111, 10);
        total++; if (col_a !== 5'd0) begin bad++; $display("FAIL cancel_col got=%0d want=0", col_a); end
        total++; if (row_a !== 5'd1) begin bad++; $display("FAIL cancel_row got=%0d want=1", row_a); end
        total++; if (col_c !== 5'd9 || row_c !== 5'd1) begin bad++; $display("FAIL cancel_clamp got=%0d,%0d want=9,1", col_c, row_c); end
        total++; if (mv_a != 1) begin bad++; $display("FAIL cancel_moved got=%0d want=1", mv_a); end
        clr();
        press(4'b1100, 10);
        total++; if (row_a !== 5'd1 || mv_a != 0) begin bad++; $display("FAIL updown_cancel got=row%0d/mv%0d want=row1/mv0", row_a, mv_a); end
        clr();
        press(4'b0101, 10);
        total++; if (col_a !== 5'd1 || row_a !== 5'd2) begin bad++; $display("FAIL diag got=%0d,%0d want=1,2", col_a, row_a); end
        total++; if (col_c !== 5'd9 || row_c !== 5'd2 || mv_c != 1) begin bad++; $display("FAIL diag_clamp got=%0d,%0d/mv%0d want=9,2/mv1", col_c, row_c, mv_c); end
    endtask

    task automatic test_move_en();
        clr();
        move_en = 1'b0;
        press(4'b0001, 10);
        move_en = 1'b1;
        step(4);
        total++; if (col_a !== 5'd1 || mv_a != 0) begin bad++; $display("FAIL move_en got=col%0d/mv%0d want=col1/mv0", col_a, mv_a); end
    endtask

    task automatic test_overlay();
        press(4'b0001, 10);
        press(4'b1000, 10);
        total++; if (col_a !== 5'd2 || row_a !== 5'd1) begin bad++; $display("FAIL overlay_pos got=%0d,%0d want=2,1", col_a, row_a); end
        active_pixels = 1'b1;
        xp = 10'd224; yp = 10'd112; step(1);
        total++; if (vga_a !== 24'hFF0000) begin bad++; $display("FAIL ovl_corner got=%h want=ff0000", vga_a); end
        total++; if (vga_c !== 24'h000000) begin bad++; $display("FAIL ovl_other_cell got=%h want=000000", vga_c); end
        xp = 10'd240; yp = 10'd128; step(1);
        total++; if (vga_a !== 24'h000000) begin bad++; $display("FAIL ovl_center got=%h want=000000", vga_a); end
        xp = 10'd226; yp = 10'd120; step(1);
        total++; if (vga_a !== 24'hFF0000) begin bad++; $display("FAIL ovl_left_border got=%h want=ff0000", vga_a); end
        xp = 10'd227; step(1);
        total++; if (vga_a !== 24'h000000) begin bad++; $display("FAIL ovl_left_inner got=%h want=000000", vga_a); end
        xp = 10'd255; step(1);
        total++; if (vga_a !== 24'hFF0000) begin bad++; $display("FAIL ovl_right_border got=%h want=ff0000", vga_a); end
        xp = 10'd256; step(1);
        total++; if (vga_a !== 24'h000000) begin bad++; $display("FAIL ovl_outside got=%h want=000000", vga_a); end
        xp = 10'd240; yp = 10'd143; step(1);
        total++; if (vga_a !== 24'hFF0000) begin bad++; $display("FAIL ovl_bottom_border got=%h want=ff0000", vga_a); end
        xp = 10'd224; yp = 10'd112; active_pixels = 1'b0; step(1);
        total++; if (vga_a !== 24'h000000) begin bad++; $display("FAIL ovl_inactive got=%h want=000000", vga_a); end
    endtask

    task automatic test_reset_held();
        key_n = 4'hE;
        step(4);
        rst = 1'b1;
        step(3);
        total++; if (col_a !== 5'd0 || row_a !== 5'd0) begin bad++; $display("FAIL rst_held_pos got=%0d,%0d want=0,0", col_a, row_a); end
        rst = 1'b0;
        clr();
        step(14);
        total++; if (col_a !== 5'd1 || mv_a != 1) begin bad++; $display("FAIL rst_held_repress got=col%0d/mv%0d want=col1/mv1", col_a, mv_a); end
        key_n = 4'hF;
        step(12);
    endtask

`ifdef CURSOR_AUTOREPEAT_EN
    task automatic test_autorepeat();
        clr();
        key_n = 4'hE;
        step(50);
        total++;
        if (pulse_t.size() < 4) begin
            bad++; $display("FAIL rpt_count got=%0d want>=4", pulse_t.size());
        end else if (pulse_t[1] - pulse_t[0] != 20 || pulse_t[2] - pulse_t[1] != 8 || pulse_t[3] - pulse_t[2] != 8) begin
            bad++; $display("FAIL rpt_spacing got=%0d,%0d,%0d want=20,8,8",
                            pulse_t[1] - pulse_t[0], pulse_t[2] - pulse_t[1], pulse_t[3] - pulse_t[2]);
        end
        rst = 1'b1;
        step(2);
        total++; if (col_a !== 5'd0) begin bad++; $display("FAIL rpt_rst_col got=%0d want=0", col_a); end
        rst = 1'b0;
        key_n = 4'hF;
        clr();
        step(40);
        total++; if (col_a !== 5'd0 || mv_a != 0) begin bad++; $display("FAIL rpt_after_rst got=col%0d/mv%0d want=col0/mv0", col_a, mv_a); end
        press(4'b0001, 10);
        total++; if (col_a !== 5'd1) begin bad++; $display("FAIL rpt_repress got=%0d want=1", col_a); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        key_n = 4'hF;
        move_en = 1'b1;
        active_pixels = 1'b0;
        xp = '0;
        yp = '0;
        test_reset();
        test_single_press();
        test_bounce();
        test_edges();
        test_cancel_diag();
        test_move_en();
        test_overlay();
        test_reset_held();
`ifdef CURSOR_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
